pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_pkg.sv | 21 ++
 rtl/pipe_stage_reg_sat_counter.sv | 34 +++
 rtl/pipe_stage_reg.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-register definitions: occupancy state encoding and nop payload fill.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    PSR_EMPTY = 2'd0,
    PSR_ONE   = 2'd1,
    PSR_FULL  = 2'd2
  } psr_state_e;

  // Bubbles carry an all-zero payload, which decodes as a nop downstream.
  localparam logic PSR_NOP_BIT = 1'b0;

  function automatic logic [1:0] psr_occ(input psr_state_e s);
    case (s)
      PSR_ONE:  return 2'd1;
      PSR_FULL: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter adding 0..3 per cycle; shared with the performance counters.
module sat_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    inc,
  input  logic          clr,
  output logic [CW-1:0] count
);

  localparam logic [CW+1:0] MAX = {2'b00, {CW{1'b1}}};

  logic [CW+1:0] sum;
  logic [CW-1:0] count_d, count_q;

  always_comb begin
    sum = {2'b00, count_q} + {{CW{1'b0}}, inc};
    if (clr)
      count_d = '0;
    else if (sum > MAX)
      count_d = MAX[CW-1:0];
    else
      count_d = sum[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional skid
// entry, synchronous flush to nop payload and a saturating squash counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DW   = 64,
  parameter bit          SKID = 1'b1,
  parameter int unsigned CW   = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  input  logic          flush,
  output logic [1:0]    occ,
  output logic [CW-1:0] flush_cnt
);

  localparam logic [DW-1:0] NOP = {DW{PSR_NOP_BIT}};

  logic       in_hs, out_hs;
  logic [1:0] flush_inc;

  assign in_hs  = s_valid && s_ready;
  assign out_hs = m_valid && m_ready;

  // The entry delivered downstream in the flush cycle is not squashed, so it is not counted.
  assign flush_inc = flush ? (occ - {1'b0, out_hs} + {1'b0, in_hs}) : 2'd0;

  generate
    if (SKID) begin : g_skid
      psr_state_e    state_q, state_d;
      logic [DW-1:0] main_q, main_d, skid_q, skid_d;
      logic          rdy_q;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = PSR_EMPTY;
          main_d  = NOP;
          skid_d  = NOP;
        end else begin
          case (state_q)
            PSR_EMPTY: if (in_hs) begin
              state_d = PSR_ONE;
              main_d  = s_data;
            end
            PSR_ONE: begin
              if (out_hs && in_hs) begin
                main_d = s_data;
              end else if (out_hs) begin
                state_d = PSR_EMPTY;
                main_d  = NOP;
              end else if (in_hs) begin
                state_d = PSR_FULL;
                skid_d  = s_data;
              end
            end
            PSR_FULL: if (out_hs) begin
              state_d = PSR_ONE;
              main_d  = skid_q;
              skid_d  = NOP;
            end
            default: begin
              state_d = PSR_EMPTY;
              main_d  = NOP;
              skid_d  = NOP;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q <= PSR_EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          rdy_q   <= 1'b1;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          rdy_q   <= (state_d != PSR_FULL);
        end
      end

      assign s_ready = rdy_q;
      assign m_valid = (state_q != PSR_EMPTY);
      assign m_data  = main_q;
      assign occ     = psr_occ(state_q);
    end else begin : g_single
      logic          valid_q, valid_d;
      logic [DW-1:0] main_q, main_d;

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
          valid_d = 1'b0;
          main_d  = NOP;
        end else if (in_hs) begin
          valid_d = 1'b1;
          main_d  = s_data;
        end else if (out_hs) begin
          valid_d = 1'b0;
          main_d  = NOP;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign s_ready = !valid_q || m_ready;
      assign m_valid = valid_q;
      assign m_data  = main_q;
      assign occ     = {1'b0, valid_q};
    end
  endgenerate

  sat_counter #(.CW(CW)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (flush_inc),
    .clr   (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two SKID=1 copies (CW=8 and CW=2) on shared stimulus and a SKID=0 copy.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset_n;

  logic          a_sv, a_mr, a_fl;
  logic [DW-1:0] a_sd;
  logic          a_s_ready, a_m_valid, b_s_ready, b_m_valid;
  logic [DW-1:0] a_m_data, b_m_data;
  logic [1:0]    a_occ, b_occ, b_cnt;
  logic [7:0]    a_cnt;

  logic          c_sv, c_mr, c_fl;
  logic [DW-1:0] c_sd;
  logic          c_s_ready, c_m_valid;
  logic [DW-1:0] c_m_data;
  logic [1:0]    c_occ;
  logic [7:0]    c_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] a_q[$];
  logic [DW-1:0] c_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DW(DW), .SKID(1'b1), .CW(8)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .s_valid(a_sv), .s_ready(a_s_ready), .s_data(a_sd),
    .m_valid(a_m_valid), .m_ready(a_mr), .m_data(a_m_data), .flush(a_fl),
    .occ(a_occ), .flush_cnt(a_cnt));

  pipe_stage_reg #(.DW(DW), .SKID(1'b1), .CW(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .s_valid(a_sv), .s_ready(b_s_ready), .s_data(a_sd),
    .m_valid(b_m_valid), .m_ready(a_mr), .m_data(b_m_data), .flush(a_fl),
    .occ(b_occ), .flush_cnt(b_cnt));

  pipe_stage_reg #(.DW(DW), .SKID(1'b0), .CW(8)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .s_valid(c_sv), .s_ready(c_s_ready), .s_data(c_sd),
    .m_valid(c_m_valid), .m_ready(c_mr), .m_data(c_m_data), .flush(c_fl),
    .occ(c_occ), .flush_cnt(c_cnt));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the SKID=1 pair: push on accepted input, pop/compare on delivery.
  always @(negedge clk) begin
    if (!reset_n) begin
      a_q.delete();
    end else begin
      checks += 4;
      if (a_occ !== 2'(a_q.size())) begin failures++; $display("FAIL mon_a_occ got=%0d exp=%0d", a_occ, a_q.size()); end
      if (b_occ !== 2'(a_q.size())) begin failures++; $display("FAIL mon_b_occ got=%0d exp=%0d", b_occ, a_q.size()); end
      if (a_m_valid !== (a_q.size() != 0)) begin failures++; $display("FAIL mon_a_valid got=%b exp=%b", a_m_valid, a_q.size() != 0); end
      if (b_m_valid !== (a_q.size() != 0)) begin failures++; $display("FAIL mon_b_valid got=%b exp=%b", b_m_valid, a_q.size() != 0); end
      if (a_m_valid !== 1'b1) begin
        checks++;
        if (a_m_data !== '0) begin failures++; $display("FAIL mon_a_bubble got=%h exp=0", a_m_data); end
      end
      if (a_m_valid === 1'b1 && a_mr === 1'b1 && a_q.size() != 0) begin
        checks += 2;
        if (a_m_data !== a_q[0]) begin failures++; $display("FAIL mon_a_data got=%h exp=%h", a_m_data, a_q[0]); end
        if (b_m_data !== a_q[0]) begin failures++; $display("FAIL mon_b_data got=%h exp=%h", b_m_data, a_q[0]); end
        void'(a_q.pop_front());
      end
      if (a_fl) a_q.delete();
      else if (a_sv && a_s_ready) a_q.push_back(a_sd);
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      c_q.delete();
    end else begin
      checks += 2;
      if (c_occ !== 2'(c_q.size())) begin failures++; $display("FAIL mon_c_occ got=%0d exp=%0d", c_occ, c_q.size()); end
      if (c_m_valid !== (c_q.size() != 0)) begin failures++; $display("FAIL mon_c_valid got=%b exp=%b", c_m_valid, c_q.size() != 0); end
      if (c_m_valid !== 1'b1) begin
        checks++;
        if (c_m_data !== '0) begin failures++; $display("FAIL mon_c_bubble got=%h exp=0", c_m_data); end
      end
      if (c_m_valid === 1'b1 && c_mr === 1'b1 && c_q.size() != 0) begin
        checks++;
        if (c_m_data !== c_q[0]) begin failures++; $display("FAIL mon_c_data got=%h exp=%h", c_m_data, c_q[0]); end
        void'(c_q.pop_front());
      end
      if (c_fl) c_q.delete();
      else if (c_sv && c_s_ready) c_q.push_back(c_sd);
    end
  end

  task automatic test_reset;
    reset_n = 1'b0;
    a_sv = 1'b0; a_mr = 1'b0; a_fl = 1'b0; a_sd = '0;
    c_sv = 1'b0; c_mr = 1'b0; c_fl = 1'b0; c_sd = '0;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if ({a_m_valid, a_m_data, a_occ, a_s_ready} !== {1'b0, 16'h0, 2'd0, 1'b1}) begin
      failures++; $display("FAIL reset_a got v=%b d=%h o=%0d r=%b exp v=0 d=0 o=0 r=1", a_m_valid, a_m_data, a_occ, a_s_ready);
    end
    if ({b_m_valid, b_m_data, b_occ, b_s_ready} !== {1'b0, 16'h0, 2'd0, 1'b1}) begin
      failures++; $display("FAIL reset_b got v=%b d=%h o=%0d r=%b exp v=0 d=0 o=0 r=1", b_m_valid, b_m_data, b_occ, b_s_ready);
    end
    if ({c_m_valid, c_m_data, c_occ, c_s_ready} !== {1'b0, 16'h0, 2'd0, 1'b1}) begin
      failures++; $display("FAIL reset_c got v=%b d=%h o=%0d r=%b exp v=0 d=0 o=0 r=1", c_m_valid, c_m_data, c_occ, c_s_ready);
    end
    if (a_cnt !== 8'd0 || c_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt_ac got=%0d/%0d exp=0", a_cnt, c_cnt); end
    if (b_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt_b got=%0d exp=0", b_cnt); end
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_stream;
    a_mr = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_sv = 1'b1; a_sd = DW'(i);
      checks++;
      if (a_s_ready !== 1'b1) begin failures++; $display("FAIL stream_ready got=%b exp=1", a_s_ready); end
      if (i > 1) begin
        checks += 2;
        if (a_m_data !== DW'(i - 1)) begin failures++; $display("FAIL stream_data got=%h exp=%h", a_m_data, DW'(i - 1)); end
        if (a_occ !== 2'd1) begin failures++; $display("FAIL stream_occ got=%0d exp=1", a_occ); end
      end
      tick;
    end
    a_sv = 1'b0; a_sd = '0;
    checks++;
    if (a_m_data !== 16'h0008) begin failures++; $display("FAIL stream_last got=%h exp=0008", a_m_data); end
    tick;
    checks++;
    if (a_m_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", a_m_valid); end
  endtask

  task automatic test_backpressure;
    a_sv = 1'b1; a_sd = 16'h000A; a_mr = 1'b0;
    tick;
    a_sd = 16'h000B;
    checks += 2;
    if (a_s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", a_s_ready); end
    if (a_m_data !== 16'h000A) begin failures++; $display("FAIL bp_head got=%h exp=000a", a_m_data); end
    tick;
    a_sd = 16'h000C;
    checks += 2;
    if (a_s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", a_s_ready); end
    if (a_occ !== 2'd2) begin failures++; $display("FAIL bp_occ_full got=%0d exp=2", a_occ); end
    tick;
    checks += 3;
    if (a_s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_hold got=%b exp=0", a_s_ready); end
    if (a_m_data !== 16'h000A) begin failures++; $display("FAIL bp_head_hold got=%h exp=000a", a_m_data); end
    if (a_occ !== 2'd2) begin failures++; $display("FAIL bp_occ_hold got=%0d exp=2", a_occ); end
    a_mr = 1'b1;
    tick;
    checks += 3;
    if (a_m_data !== 16'h000B) begin failures++; $display("FAIL bp_second got=%h exp=000b", a_m_data); end
    if (a_s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_release got=%b exp=1", a_s_ready); end
    if (a_occ !== 2'd1) begin failures++; $display("FAIL bp_occ_release got=%0d exp=1", a_occ); end
    tick;
    a_sv = 1'b0;
    checks++;
    if (a_m_data !== 16'h000C) begin failures++; $display("FAIL bp_third got=%h exp=000c", a_m_data); end
    tick;
    checks++;
    if (a_m_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", a_m_valid); end
  endtask

  task automatic test_flush_full;
    a_sv = 1'b1; a_sd = 16'h0011; a_mr = 1'b0;
    tick;
    a_sd = 16'h0022;
    tick;
    a_sd = 16'h0033; a_fl = 1'b1;
    checks++;
    if (a_s_ready !== 1'b0) begin failures++; $display("FAIL ff_ready got=%b exp=0", a_s_ready); end
    tick;
    a_fl = 1'b0; a_sv = 1'b0;
    checks += 3;
    if ({a_m_valid, a_m_data, a_occ} !== {1'b0, 16'h0, 2'd0}) begin
      failures++; $display("FAIL ff_state got v=%b d=%h o=%0d exp v=0 d=0 o=0", a_m_valid, a_m_data, a_occ);
    end
    if (a_cnt !== 8'd2) begin failures++; $display("FAIL ff_cnt_a got=%0d exp=2", a_cnt); end
    if (b_cnt !== 2'd2) begin failures++; $display("FAIL ff_cnt_b got=%0d exp=2", b_cnt); end
  endtask

  task automatic test_flush_one;
    a_sv = 1'b1; a_sd = 16'h0044; a_mr = 1'b1;
    tick;
    a_sd = 16'h0055; a_fl = 1'b1;
    checks++;
    if ({a_m_valid, a_m_data} !== {1'b1, 16'h0044}) begin
      failures++; $display("FAIL fo_deliver got v=%b d=%h exp v=1 d=0044", a_m_valid, a_m_data);
    end
    tick;
    a_fl = 1'b0; a_sv = 1'b0;
    checks += 3;
    if (a_occ !== 2'd0) begin failures++; $display("FAIL fo_occ got=%0d exp=0", a_occ); end
    if (a_cnt !== 8'd3) begin failures++; $display("FAIL fo_cnt_a got=%0d exp=3", a_cnt); end
    if (b_cnt !== 2'd3) begin failures++; $display("FAIL fo_cnt_b got=%0d exp=3", b_cnt); end
    tick;
    checks++;
    if (a_m_valid !== 1'b0) begin failures++; $display("FAIL fo_discard got=%b exp=0", a_m_valid); end
  endtask

  task automatic test_saturation;
    a_sv = 1'b1; a_sd = 16'h0066; a_mr = 1'b0;
    tick;
    a_sd = 16'h0077; a_fl = 1'b1;
    tick;
    a_fl = 1'b0; a_sv = 1'b0;
    checks += 2;
    if (a_cnt !== 8'd5) begin failures++; $display("FAIL sat1_cnt_a got=%0d exp=5", a_cnt); end
    if (b_cnt !== 2'd3) begin failures++; $display("FAIL sat1_cnt_b got=%0d exp=3", b_cnt); end
    a_sv = 1'b1; a_sd = 16'h0088;
    tick;
    a_sd = 16'h0099;
    tick;
    a_fl = 1'b1;
    tick;
    a_fl = 1'b0; a_sv = 1'b0;
    checks += 2;
    if (a_cnt !== 8'd7) begin failures++; $display("FAIL sat2_cnt_a got=%0d exp=7", a_cnt); end
    if (b_cnt !== 2'd3) begin failures++; $display("FAIL sat2_cnt_b got=%0d exp=3", b_cnt); end
    a_mr = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid;
    a_mr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_sv = 1'b1; a_sd = DW'(16'h00A0 + i);
      tick;
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if ({a_m_valid, a_m_data, a_occ, a_s_ready} !== {1'b0, 16'h0, 2'd0, 1'b1}) begin
      failures++; $display("FAIL rm_state got v=%b d=%h o=%0d r=%b exp v=0 d=0 o=0 r=1", a_m_valid, a_m_data, a_occ, a_s_ready);
    end
    if (a_cnt !== 8'd0) begin failures++; $display("FAIL rm_cnt_a got=%0d exp=0", a_cnt); end
    if (b_cnt !== 2'd0) begin failures++; $display("FAIL rm_cnt_b got=%0d exp=0", b_cnt); end
    a_sv = 1'b0; a_sd = '0;
    tick;
    reset_n = 1'b1;
    tick;
    checks++;
    if ({a_s_ready, a_m_valid} !== 2'b10) begin
      failures++; $display("FAIL rm_release got r=%b v=%b exp r=1 v=0", a_s_ready, a_m_valid);
    end
  endtask

  task automatic test_skid0_stream;
    c_mr = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      c_sv = 1'b1; c_sd = DW'(i);
      checks++;
      if (c_s_ready !== 1'b1) begin failures++; $display("FAIL s0_stream_ready got=%b exp=1", c_s_ready); end
      if (i > 1) begin
        checks += 2;
        if (c_m_data !== DW'(i - 1)) begin failures++; $display("FAIL s0_stream_data got=%h exp=%h", c_m_data, DW'(i - 1)); end
        if (c_occ !== 2'd1) begin failures++; $display("FAIL s0_stream_occ got=%0d exp=1", c_occ); end
      end
      tick;
    end
    c_sv = 1'b0; c_sd = '0;
    checks++;
    if (c_m_data !== 16'h0008) begin failures++; $display("FAIL s0_stream_last got=%h exp=0008", c_m_data); end
    tick;
  endtask

  task automatic test_skid0_backpressure;
    c_sv = 1'b1; c_sd = 16'h000A; c_mr = 1'b0;
    tick;
    c_sd = 16'h000B;
    checks += 2;
    if (c_s_ready !== 1'b0) begin failures++; $display("FAIL s0_bp_ready got=%b exp=0", c_s_ready); end
    if (c_occ !== 2'd1) begin failures++; $display("FAIL s0_bp_occ got=%0d exp=1", c_occ); end
    tick;
    tick;
    checks++;
    if (c_m_data !== 16'h000A) begin failures++; $display("FAIL s0_bp_head got=%h exp=000a", c_m_data); end
    c_mr = 1'b1;
    #1;
    checks++;
    if (c_s_ready !== 1'b1) begin failures++; $display("FAIL s0_bp_comb_ready got=%b exp=1", c_s_ready); end
    tick;
    c_sd = 16'h000C;
    checks++;
    if (c_m_data !== 16'h000B) begin failures++; $display("FAIL s0_bp_second got=%h exp=000b", c_m_data); end
    tick;
    c_sv = 1'b0;
    checks++;
    if (c_m_data !== 16'h000C) begin failures++; $display("FAIL s0_bp_third got=%h exp=000c", c_m_data); end
    tick;
    checks++;
    if (c_m_valid !== 1'b0) begin failures++; $display("FAIL s0_bp_drain got=%b exp=0", c_m_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_one();
    test_saturation();
    test_reset_mid();
    test_skid0_stream();
    test_skid0_backpressure();
    repeat (2) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
